// File: rtl/packer_pkg.sv
// Shared definitions for the nibble packer: nibble width and the FILL/OUT state encoding.
package packer_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } state_e;

endpackage

// File: rtl/nibble_packer.sv
// Packs nibbles popped from an upstream FIFO into NIBBLES-wide words and presents
// each full (or flushed partial) word on a valid/ready output until accepted.
module nibble_packer
    import packer_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             empty,
    input  logic [NIBBLE_W-1:0]              read_data,
    output logic                             read_en,
    input  logic                             flush,
    output logic [NIBBLE_W*NIBBLES-1:0]      out_data,
    output logic [$clog2(NIBBLES+1)-1:0]     out_cnt,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int                CNT_W    = $clog2(NIBBLES + 1);
    localparam int                DATA_W   = NIBBLE_W * NIBBLES;
    localparam logic [CNT_W-1:0]  ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NIBBLES);
    localparam logic [DATA_W-1:0] ZERO_DAT = {DATA_W{1'b0}};

    state_e              state_r;
    state_e              state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    logic [DATA_W-1:0]   data_s;
    logic [CNT_W-1:0]    out_cnt_s;
    logic                valid_s;

    // Pop request: only while collecting, never on a flush cycle, never out of reset.
    always_comb begin
        if (rst) begin
            read_en = 1'b0;
        end else begin
            read_en = (state_r == FILL) && !empty && !flush;
        end
    end

    // Next-state and next-output logic for the FILL/OUT machine.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        data_s    = out_data;
        out_cnt_s = out_cnt;
        valid_s   = out_valid;
        case (state_r)
            FILL: begin
                // A flush with nothing collected is dropped; unfilled nibbles are already zero.
                if (flush && (cnt_r != ZERO_CNT)) begin
                    state_s   = OUT;
                    out_cnt_s = cnt_r;
                    valid_s   = 1'b1;
                    cnt_s     = ZERO_CNT;
                end else if (read_en) begin
                    data_s[int'(cnt_r)*NIBBLE_W +: NIBBLE_W] = read_data;
                    if (cnt_r == LAST_IDX) begin
                        state_s   = OUT;
                        out_cnt_s = FULL_CNT;
                        valid_s   = 1'b1;
                        cnt_s     = ZERO_CNT;
                    end else begin
                        cnt_s = cnt_r + ONE_CNT;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_s   = FILL;
                    valid_s   = 1'b0;
                    data_s    = ZERO_DAT;
                    out_cnt_s = ZERO_CNT;
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s   = FILL;
                cnt_s     = ZERO_CNT;
                data_s    = ZERO_DAT;
                out_cnt_s = ZERO_CNT;
                valid_s   = 1'b0;
            end
        endcase
    end

    // State, counter and registered output word with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= FILL;
            cnt_r     <= ZERO_CNT;
            out_data  <= ZERO_DAT;
            out_cnt   <= ZERO_CNT;
            out_valid <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            out_data  <= data_s;
            out_cnt   <= out_cnt_s;
            out_valid <= valid_s;
        end
    end

endmodule

// File: doc/nibble_packer.md
NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning the number of 4-bit nibbles per output word (legal values 2..8).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-004 SHALL have port empty, input, 1 bit, the upstream FIFO empty flag.
REQ-005 SHALL have port read_data, input, 4 bits, the upstream FIFO head nibble; it is valid combinationally whenever empty=0.
REQ-006 SHALL have port read_en, output, 1 bit, the pop request to the FIFO; it is combinational.
REQ-007 SHALL have port flush, input, 1 bit, a single-cycle request to emit a partial word.
REQ-008 SHALL have port out_data, output, 4*NIBBLES bits, the packed word.
REQ-009 SHALL have port out_cnt, output, $clog2(NIBBLES+1) bits, the number of valid nibbles in out_data.
REQ-010 SHALL have port out_valid, output, 1 bit, output handshake valid.
REQ-011 SHALL have port out_ready, input, 1 bit, output handshake ready.

Function
REQ-012 SHALL implement a two-state FSM: FILL (collecting nibbles) and OUT (word held for the consumer).
REQ-013 SHALL drive read_en = (state==FILL) && !empty && !flush; a pop happens in any cycle where read_en=1.
REQ-014 SHALL capture read_data in the same cycle as the pop and place it at out_data[4*cnt+3 : 4*cnt]; the first nibble popped goes to bits [3:0].
REQ-015 SHALL increment the internal counter cnt on each pop; the pop that makes cnt reach NIBBLES SHALL, at that clock edge, set state=OUT, out_cnt=NIBBLES, out_valid=1, and reset cnt to 0.
REQ-016 SHALL handle flush in FILL as follows: if cnt>0, go to OUT with out_cnt=cnt and the unfilled nibbles of out_data zero; if cnt=0, ignore flush with no state change.
REQ-017 SHALL ignore flush while in OUT; the request is not queued.
REQ-018 SHALL hold out_data, out_cnt and out_valid stable while in OUT with out_ready=0.
REQ-019 SHALL, when in OUT and out_ready=1, complete the transfer at that edge; the next cycle is FILL with out_valid=0 and out_data cleared to 0.
REQ-020 SHALL NOT pop during OUT, giving a minimum of NIBBLES+1 cycles per full word.
REQ-021 SHALL make out_valid a registered signal with no combinational path from out_ready to out_valid.
REQ-022 SHALL make read_en depend only on state, empty and flush, and never on out_ready.
REQ-023 SHALL wrap cnt with no overflow: it never exceeds NIBBLES-1 in FILL.

Reset
REQ-024 SHALL, while rst=1 at a rising edge, set state=FILL, cnt=0, out_data=0, out_cnt=0 and out_valid=0.
REQ-025 SHALL force read_en=0 while rst=1.
REQ-026 SHALL discard a partial or held word on reset mid-operation; no word is emitted for it.

Structure
REQ-027 SHALL place the FSM state enum (FILL, OUT) and the NIBBLE_W=4 constant in the shared package packer_pkg.
REQ-028 SHALL be a single flat module with no sub-modules; the packing shift register is inline.

Verification
REQ-029 SHALL cover the full word case: FIFO preloaded with 1,2,3,4 and out_ready=1 -> read_en high for 4 cycles, then out_valid=1 with out_data=16'h4321 and out_cnt=4 for 1 cycle.
REQ-030 SHALL cover backpressure: out_ready=0 after a word forms -> out_valid held and out_data stable for 10 cycles, read_en=0 throughout; then out_ready=1 -> transfer completes and popping resumes the next cycle.
REQ-031 SHALL cover a partial flush: pop A,B, then pulse flush with FIFO non-empty -> that cycle read_en=0, then out_data=16'h00BA and out_cnt=2.
REQ-032 SHALL cover an empty flush: flush with cnt=0 -> no out_valid and the FSM stays in FILL; flush during OUT -> ignored.
REQ-033 SHALL cover an underrun: FIFO empty after 3 pops -> read_en=0 and cnt holds at 3; one more nibble arrives -> the word is emitted correctly.
REQ-034 SHALL cover reset mid-operation: rst pulsed with cnt=2, and again in OUT -> all outputs 0 and the next word starts from bits [3:0].
